// File: rtl/unary_stream_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : unary_stream_gen_if
// Description : Load handshake, operand, stall and unary stream signals
//               between a unary stream generator and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
interface unary_stream_gen_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_val;
    logic [7:0] b_val;
    logic [7:0] a_len;
    logic [7:0] b_len;
    logic       hold;
    logic       a;
    logic       b;
    logic [1:0] ready;
    logic       busy;
    logic       done;

    // Producer side: issues loads and stalls, observes the streams.
    modport master (
        output in_valid, a_val, b_val, a_len, b_len, hold,
        input  in_ready, a, b, ready, busy, done
    );

    // Generator side.
    modport slave (
        input  in_valid, a_val, b_val, a_len, b_len, hold,
        output in_ready, a, b, ready, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/unary_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : unary_stream_gen
// Description : Converts two binary magnitudes into parallel thermometer-coded
//               unary bit streams with per-channel frame length and stall.
// Revision    : 1.0 - initial release
// ============================================================================
module unary_stream_gen (
    input  wire logic         clk,
    input  wire logic         reset,
    unary_stream_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_armed;
    logic [7:0] r_a_val;
    logic [7:0] r_b_val;
    logic [7:0] r_a_len;
    logic [7:0] r_b_len;
    logic [7:0] r_a_cnt;
    logic [7:0] r_b_cnt;

    logic       w_load;
    logic       w_a_qual;
    logic       w_b_qual;
    logic [7:0] w_a_cnt_nxt;
    logic [7:0] w_b_cnt_nxt;

    // Qualification, counter advance and next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = (r_state == IDLE) && r_armed && bus.in_valid;
        // A channel is qualified while its counter is short of its length;
        // the counter only advances on qualified cycles, so it stops at len.
        w_a_qual    = (r_state == STREAM) && !bus.hold && (r_a_cnt < r_a_len);
        w_b_qual    = (r_state == STREAM) && !bus.hold && (r_b_cnt < r_b_len);
        w_a_cnt_nxt = r_a_cnt + {7'd0, w_a_qual};
        w_b_cnt_nxt = r_b_cnt + {7'd0, w_b_qual};
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    // Empty frame on both channels skips straight to DONE.
                    if ((bus.a_len == 8'd0) && (bus.b_len == 8'd0))
                        w_state_nxt = DONE;
                    else
                        w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if ((w_a_cnt_nxt == r_a_len) && (w_b_cnt_nxt == r_b_len))
                    w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // in_ready is withheld until the first clock edge seen out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_armed <= 1'b0;
        else        r_armed <= 1'b1;
    end

    // Operand capture on load; per-channel counters run during the frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_val <= 8'd0;
            r_b_val <= 8'd0;
            r_a_len <= 8'd0;
            r_b_len <= 8'd0;
            r_a_cnt <= 8'd0;
            r_b_cnt <= 8'd0;
        end else if (w_load) begin
            r_a_val <= bus.a_val;
            r_b_val <= bus.b_val;
            r_a_len <= bus.a_len;
            r_b_len <= bus.b_len;
            r_a_cnt <= 8'd0;
            r_b_cnt <= 8'd0;
        end else begin
            r_a_cnt <= w_a_cnt_nxt;
            r_b_cnt <= w_b_cnt_nxt;
        end
    end

    // Thermometer bit: 1 while the counter is below the value; values above
    // the length saturate naturally because qualification ends at len.
    assign bus.a        = w_a_qual && (r_a_cnt < r_a_val);
    assign bus.b        = w_b_qual && (r_b_cnt < r_b_val);
    assign bus.ready    = {w_a_qual, w_b_qual};
    assign bus.in_ready = (r_state == IDLE) && r_armed;
    assign bus.busy     = (r_state == STREAM);
    assign bus.done     = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_unary_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_unary_stream_gen
// Description : Scoreboard bench for unary_stream_gen: accepted loads push the
//               expected per-channel bit sequences, a monitor pops and checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unary_stream_gen;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    unary_stream_gen_if bus ();

    unary_stream_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame phase plus queues of the bits still owed.
    int m_mode     = 0;   // 0 idle, 1 streaming, 2 completion cycle
    bit m_armed    = 1'b0;
    bit qa[$];
    bit qb[$];
    int done_seen  = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Expected response of a frame: min(val,len) ones, then zeros, len bits.
    function automatic void push_frame(input int av, input int al, input int bv, input int bl);
        for (int i = 0; i < al; i++) qa.push_back(i < av);
        for (int i = 0; i < bl; i++) qb.push_back(i < bv);
    endfunction

    // Monitor: samples mid-cycle, compares against the queues, advances model.
    always @(negedge clk) begin
        bit ra, rb, ea, eb, ir;
        if (!reset) begin
            chk("rst_in_ready", {7'd0, bus.in_ready}, 8'd0);
            chk("rst_ready", {6'd0, bus.ready}, 8'd0);
            chk("rst_ab", {6'd0, bus.a, bus.b}, 8'd0);
            chk("rst_busy_done", {6'd0, bus.busy, bus.done}, 8'd0);
            m_mode  = 0;
            m_armed = 1'b0;
            qa.delete();
            qb.delete();
        end else begin
            ir = (m_mode == 0) && m_armed;
            chk("in_ready", {7'd0, bus.in_ready}, {7'd0, ir});
            chk("busy", {7'd0, bus.busy}, {7'd0, (m_mode == 1)});
            chk("done", {7'd0, bus.done}, {7'd0, (m_mode == 2)});
            ra = (m_mode == 1) && !bus.hold && (qa.size() > 0);
            rb = (m_mode == 1) && !bus.hold && (qb.size() > 0);
            ea = ra ? qa[0] : 1'b0;
            eb = rb ? qb[0] : 1'b0;
            chk("ready", {6'd0, bus.ready}, {6'd0, ra, rb});
            chk("a_bit", {7'd0, bus.a}, {7'd0, ea});
            chk("b_bit", {7'd0, bus.b}, {7'd0, eb});
            if (ra) void'(qa.pop_front());
            if (rb) void'(qb.pop_front());
            if (m_mode == 2) done_seen++;
            case (m_mode)
                0: if (ir && bus.in_valid) begin
                       push_frame(bus.a_val, bus.a_len, bus.b_val, bus.b_len);
                       m_mode = (qa.size() == 0 && qb.size() == 0) ? 2 : 1;
                   end
                1: if (qa.size() == 0 && qb.size() == 0) m_mode = 2;
                default: m_mode = 0;
            endcase
            m_armed = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.in_ready !== 1'b1 && k < 300) begin
            step();
            k++;
        end
        if (k >= 300) timeout("wait_in_ready");
    endtask

    task automatic load(input logic [7:0] av, input logic [7:0] al,
                        input logic [7:0] bv, input logic [7:0] bl);
        wait_idle();
        bus.in_valid = 1'b1;
        bus.a_val    = av;
        bus.a_len    = al;
        bus.b_val    = bv;
        bus.b_len    = bl;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic run_to_done(input int hold_pct);
        int start = done_seen;
        int k     = 0;
        while (done_seen == start && k < 700) begin
            bus.hold = (hold_pct > 0) && ($urandom_range(99) < hold_pct);
            step();
            k++;
        end
        bus.hold = 1'b0;
        if (k >= 700) timeout("wait_done");
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a_val    = 8'd0;
        bus.b_val    = 8'd0;
        bus.a_len    = 8'd0;
        bus.b_len    = 8'd0;
        bus.hold     = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();

        // Full a, empty b, equal lengths.
        load(8'd8, 8'd8, 8'd0, 8'd8);
        run_to_done(0);
        step();

        // Unequal lengths, b saturates.
        load(8'd3, 8'd5, 8'd6, 8'd4);
        run_to_done(0);

        // Single hold in the second stream cycle.
        load(8'd2, 8'd4, 8'd2, 8'd4);
        bus.hold = 1'b0;
        step();
        bus.hold = 1'b1;
        step();
        bus.hold = 1'b0;
        run_to_done(0);

        // Zero-length frame.
        load(8'd5, 8'd0, 8'd7, 8'd0);
        run_to_done(0);

        // Reset mid-frame, then a fresh frame.
        load(8'd10, 8'd10, 8'd4, 8'd10);
        step();
        step();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        load(8'd4, 8'd6, 8'd9, 8'd3);
        run_to_done(0);

        // in_valid held high while operands change during the frame.
        wait_idle();
        bus.in_valid = 1'b1;
        bus.a_val    = 8'd5;
        bus.a_len    = 8'd7;
        bus.b_val    = 8'd2;
        bus.b_len    = 8'd3;
        begin
            int start = done_seen;
            int k     = 0;
            while (done_seen == start && k < 50) begin
                step();
                bus.a_val = 8'($urandom);
                k++;
            end
            if (k >= 50) timeout("held_valid_done");
        end
        step();
        bus.in_valid = 1'b0;
        run_to_done(0);

        // Randomized frames with random stalls.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] al, bl;
            al = ($urandom_range(9) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(20));
            bl = ($urandom_range(9) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(20));
            load(8'($urandom_range(30)), al, 8'($urandom_range(30)), bl);
            run_to_done(25);
            repeat ($urandom_range(2)) begin
                bus.hold = $urandom_range(1);
                step();
            end
            bus.hold = 1'b0;
        end

        step();
        chk("final_queues_empty", 8'(qa.size() + qb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unary_stream_gen.md
UNARY_STREAM_GEN -- requirements
Module: unary_stream_gen

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-003 SHALL have port in_valid, input, 1 bit: request to load a new operand pair.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a load this cycle.
REQ-005 SHALL have ports a_val and b_val, input, 8 bits each: binary magnitudes to encode.
REQ-006 SHALL have ports a_len and b_len, input, 8 bits each: per-channel frame length in cycles.
REQ-007 SHALL have port hold, input, 1 bit: stall request from the downstream unary unit.
REQ-008 SHALL have ports a and b, output, 1 bit each: unary stream bits.
REQ-009 SHALL have port ready, output, 2 bits: ready[1] qualifies a, ready[0] qualifies b.
REQ-010 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-012 SHALL implement FSM states IDLE, STREAM, DONE.
REQ-013 IDLE: in_ready=1, busy=0; in_valid=1 at a rising edge captures a_val, b_val, a_len, b_len and moves to STREAM.
REQ-014 Load latency: first qualified stream bit SHALL appear in the cycle immediately after the capturing edge.
REQ-015 Per channel, SHALL emit thermometer code: bit=1 for the first min(val,len) qualified cycles, then bit=0 for the rest of len cycles.
REQ-016 val greater than len SHALL saturate to len (all ones), with no error flag.
REQ-017 ready[i] SHALL be 1 exactly for len_i qualified cycles of its channel, then 0 until the next frame.
REQ-018 Channels SHALL run in parallel from the same start cycle; the shorter channel deasserts its ready bit while the longer continues.
REQ-019 Stream bit a/b SHALL be 0 whenever its ready bit is 0.
REQ-020 Per-channel cycle counters SHALL be 8 bits and SHALL never wrap: each stops at len_i.
REQ-021 hold=1 SHALL freeze both counters, force ready=2'b00 and a=b=0 that cycle; the stream resumes unchanged when hold=0.
REQ-022 STREAM -> DONE SHALL occur on the edge after both channels have emitted their last qualified bit; DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-023 a_len=b_len=0 on load SHALL go directly to DONE with no qualified bits (done on the cycle after the load).
REQ-024 in_ready SHALL be 0 in STREAM and DONE; in_valid there SHALL be ignored (no queuing).
REQ-025 busy SHALL be 1 in STREAM only.
REQ-026 hold during DONE or IDLE SHALL have no effect.

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, a=b=0, ready=2'b00, busy=0, done=0, in_ready=0, and clear counters and captured operands.
REQ-028 in_ready SHALL become 1 on the first rising edge after reset deasserts.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no done pulse.

Verification
REQ-030 Load a_val=8,a_len=8,b_val=0,b_len=8 -> 8 cycles of ready=11, a=1, b=0; then ready=00, one done pulse, in_ready=1.
REQ-031 Load a_val=3,a_len=5,b_val=6,b_len=4 -> a=1,1,1,0,0 with ready[1] for 5 cycles; b=1,1,1,1 with ready[0] for 4 cycles (saturated); done after cycle 5.
REQ-032 Load a_val=2,a_len=4,b_val=2,b_len=4, hold=1 in stream cycle 2 -> that cycle ready=00; totals still 2 ones in 4 qualified cycles per channel; done delayed by 1.
REQ-033 Load a_len=b_len=0 -> ready stays 00, done pulses the cycle after load, back in IDLE.
REQ-034 Reset low at stream cycle 3 of a 10-cycle frame -> outputs zero at once, no done; after release a new load streams correctly.
REQ-035 in_valid held high through a frame with changing a_val -> only the first-captured values streamed; next load accepted only after done.
